// File: rtl/disp_pkg.sv
// Shared definitions for the ALU result display: converter state encoding,
// active-low seven-segment patterns (g..a), double-dabble adjust step and
// digit decoder.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } conv_state_t;

  localparam int DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Nibbles above 9 never come out of the converter; they decode to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd8_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
//
// state | meaning
// IDLE  | waiting for start; bcd holds the last result
// SHIFT | one adjust+shift iteration per clock, 8 iterations
// WRITE | publish scratch to bcd, return to IDLE
//
// Ports:
//   clk, rst (async, active-low), start (sampled in IDLE), bin[7:0],
//   busy (state != IDLE), bcd[11:0] {hundreds, tens, units},
//   bcd_valid (high for the one WRITE cycle; bcd updates at its closing edge).
module bin2bcd8_seq
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        bcd_valid
);

  conv_state_t state;
  logic [7:0]  bin_sh;
  logic [11:0] scratch;
  logic [11:0] scratch_adj;
  logic [2:0]  iter;

  assign scratch_adj = dd_adjust(scratch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bin_sh  <= '0;
      scratch <= '0;
      iter    <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sh  <= bin;
            scratch <= '0;
            iter    <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, bin_sh} <= {scratch_adj[10:0], bin_sh, 1'b0};
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= WRITE;
        end
        WRITE: begin
          bcd   <= scratch;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign bcd_valid = (state == WRITE);

endmodule

// File: rtl/alu_result_display.sv
// ALU result display: samples Y/zero/overflow on done, converts Y to BCD and
// scans a 4-digit active-low seven-segment display (overflow, hundreds, tens,
// units).
//
// Ports:
//   clk, rst (async, active-low), done_in, y_in[7:0], zero_in, ovf_in,
//   busy, bcd_out[11:0], seg[6:0] (a = bit 0), dp, an[3:0] (an[0] = units).
module alu_result_display
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done_in,
  input  logic [7:0]  y_in,
  input  logic        zero_in,
  input  logic        ovf_in,
  output logic        busy,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);

  logic          bcd_valid;
  logic          capture;
  logic          snap_zero, snap_ovf;
  logic          disp_zero, disp_ovf;
  logic [CW-1:0] refresh_cnt;
  logic          refresh_wrap;
  logic [IW-1:0] digit_idx, idx_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;
  logic [3:0]    hundreds, tens, units;

  assign capture = done_in & ~busy;

  bin2bcd8_seq u_conv (
    .clk       (clk),
    .rst       (rst),
    .start     (done_in),
    .bin       (y_in),
    .busy      (busy),
    .bcd       (bcd_out),
    .bcd_valid (bcd_valid)
  );

  // Flags are snapshotted with Y and only shown once the matching BCD lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_zero <= 1'b0;
      snap_ovf  <= 1'b0;
      disp_zero <= 1'b0;
      disp_ovf  <= 1'b0;
    end else begin
      if (capture) begin
        snap_zero <= zero_in;
        snap_ovf  <= ovf_in;
      end
      if (bcd_valid) begin
        disp_zero <= snap_zero;
        disp_ovf  <= snap_ovf;
      end
    end
  end

  assign refresh_wrap = (refresh_cnt == CW'(REFRESH_DIV - 1));
  assign idx_nxt      = refresh_wrap ? digit_idx + IW'(1) : digit_idx;

  assign hundreds = bcd_out[11:8];
  assign tens     = bcd_out[7:4];
  assign units    = bcd_out[3:0];

  // Segment content is computed for the slot that becomes active at this
  // edge, so seg and an switch together.
  always_comb begin
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    case (idx_nxt)
      2'd0: begin
        seg_nxt = seg_decode(units);
        dp_nxt  = ~disp_zero;
      end
      2'd1: if (hundreds != 4'd0 || tens != 4'd0) seg_nxt = seg_decode(tens);
      2'd2: if (hundreds != 4'd0) seg_nxt = seg_decode(hundreds);
      2'd3: if (disp_ovf) seg_nxt = SEG_E;
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      an          <= 4'hF;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + CW'(1);
      digit_idx   <= idx_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
      an          <= ~(4'b0001 << idx_nxt);
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SE = 7'b0000110, SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_in;
  logic [7:0]  y_in;
  logic        zero_in;
  logic        ovf_in;
  logic        busy;
  logic [11:0] bcd_out;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0]       y;
    logic             z;
    logic             o;
    logic [11:0]      bcd;
    logic [3:0][6:0]  seg;   // index = slot (0 = units)
    logic [3:0]       dp;    // index = slot
  } vec_t;

  vec_t vecs [9];

  alu_result_display #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .done_in (done_in),
    .y_in    (y_in),
    .zero_in (zero_in),
    .ovf_in  (ovf_in),
    .busy    (busy),
    .bcd_out (bcd_out),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Observe 16 consecutive clocks (one full scan) and check every slot seen.
  task automatic scan(input string nm, input logic [3:0][6:0] es, input logic [3:0] edp);
    int slot;
    logic valid;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      valid = 1'b0;
      slot  = 0;
      for (int s = 0; s < 4; s++) begin
        if (an == ~(4'b0001 << s)) begin
          valid = 1'b1;
          slot  = s;
        end
      end
      chk({nm, "_an_onehot"}, {31'd0, valid}, 32'd1);
      if (valid) begin
        chk({nm, "_seg"}, {25'd0, seg}, {25'd0, es[slot]});
        chk({nm, "_dp"},  {31'd0, dp},  {31'd0, edp[slot]});
      end
    end
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    y_in    = vecs[i].y;
    zero_in = vecs[i].z;
    ovf_in  = vecs[i].o;
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    wait_idle(20);
    chk($sformatf("vec%0d_bcd", i), {20'd0, bcd_out}, {20'd0, vecs[i].bcd});
    repeat (2) @(negedge clk);
    scan($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp);
  endtask

  initial begin
    logic [3:0] exp_an;
    logic       saw_busy;

    //           y      z     o     bcd      seg {slot3, slot2, slot1, slot0}  dp
    vecs[0] = '{8'd7,   1'b0, 1'b0, 12'h007, {SB, SB, SB, S7}, 4'b1111};
    vecs[1] = '{8'd0,   1'b1, 1'b0, 12'h000, {SB, SB, SB, S0}, 4'b1110};
    vecs[2] = '{8'd200, 1'b0, 1'b1, 12'h200, {SE, S2, S0, S0}, 4'b1111};
    vecs[3] = '{8'd255, 1'b0, 1'b0, 12'h255, {SB, S2, S5, S5}, 4'b1111};
    vecs[4] = '{8'd45,  1'b0, 1'b1, 12'h045, {SE, SB, S4, S5}, 4'b1111};
    vecs[5] = '{8'd10,  1'b0, 1'b0, 12'h010, {SB, SB, S1, S0}, 4'b1111};
    vecs[6] = '{8'd138, 1'b1, 1'b1, 12'h138, {SE, S1, S3, S8}, 4'b1110};
    vecs[7] = '{8'd99,  1'b0, 1'b0, 12'h099, {SB, SB, S9, S9}, 4'b1111};
    vecs[8] = '{8'd64,  1'b0, 1'b0, 12'h064, {SB, SB, S6, S4}, 4'b1111};

    // Reset with a live done/Y on the bus
    rst = 1'b0; done_in = 1'b1; y_in = 8'hFF; zero_in = 1'b0; ovf_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg",  {25'd0, seg},     {25'd0, SB});
    chk("rst_an",   {28'd0, an},      32'hF);
    chk("rst_dp",   {31'd0, dp},      32'd1);
    chk("rst_busy", {31'd0, busy},    32'd0);
    chk("rst_bcd",  {20'd0, bcd_out}, 32'h000);

    // Release: capture of 255 at edge 1 (k), result at edge 10, recapture at 11
    rst = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << ((n / 4) % 4));
      chk($sformatf("lat_an_e%0d", n),   {28'd0, an},      {28'd0, exp_an});
      chk($sformatf("lat_busy_e%0d", n), {31'd0, busy},    (n == 10) ? 32'd0 : 32'd1);
      chk($sformatf("lat_bcd_e%0d", n),  {20'd0, bcd_out}, (n >= 10) ? 32'h255 : 32'h000);
    end
    // Drop done mid-conversion: second conversion must still complete
    done_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_drop_busy", {31'd0, busy}, 32'd1);
    wait_idle(20);
    chk("done_drop_bcd", {20'd0, bcd_out}, 32'h255);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Inputs wiggling during conversion are ignored
    @(negedge clk);
    y_in = 8'd99; zero_in = 1'b0; ovf_in = 1'b0; done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);
    y_in = 8'd150; zero_in = 1'b1; ovf_in = 1'b1; done_in = 1'b1;
    repeat (3) @(negedge clk);
    done_in = 1'b0;
    wait_idle(20);
    chk("midchg_bcd", {20'd0, bcd_out}, 32'h099);
    repeat (2) @(negedge clk);
    scan("midchg", {SB, SB, S9, S9}, 4'b1111);

    // Reset during SHIFT iteration 4
    @(negedge clk);
    y_in = 8'd150; done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy},    32'd0);
    chk("abort_bcd",  {20'd0, bcd_out}, 32'h000);
    chk("abort_seg",  {25'd0, seg},     {25'd0, SB});
    chk("abort_an",   {28'd0, an},      32'hF);
    chk("abort_dp",   {31'd0, dp},      32'd1);
    @(negedge clk);
    rst = 1'b1;
    saw_busy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    chk("post_rst_no_capture", {31'd0, saw_busy}, 32'd0);
    chk("post_rst_bcd", {20'd0, bcd_out}, 32'h000);
    scan("post_rst", {SB, SB, SB, S0}, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
